md5_msg_pad: RTL and testbench
==============================

// Module: md5_msg_pad
// PURPOSE
//  Upstream feeder for md5core. Collects one candidate message as a byte stream.
//  Applies MD5 padding: 0x80 marker, zero fill, 64-bit little-endian bit length.
//  Presents the finished 512-bit block on mesg with a valid/ready handshake.
//  Single-block messages only (1..MAX_LEN bytes); a longer message is dropped and flagged.
// PARAMETERS
//  MAX_LEN  55  max message bytes per block; legal range 1..55
// PORTS
//  clk          in   1    system clock; all logic on rising edge
//  reset        in   1    synchronous, active-high
//  in_data      in   8    message byte; first byte of message sent first
//  in_valid     in   1    in_data valid
//  in_last      in   1    qualifies in_valid: this is the final byte of the message
//  in_ready     out  1    block accepts a byte this cycle
//  mesg         out  512  padded block; byte k at mesg[511-8k -: 8]
//  mesg_valid   out  1    mesg holds a complete padded block
//  mesg_ready   in   1    consumer (md5core control) takes mesg
//  msg_len      out  6    byte count of the block on mesg
//  err_ovf      out  1    one-cycle pulse: message exceeded MAX_LEN, discarded
// BEHAVIOUR
//  Reset: state=COLLECT, buffer=0, count=0, ovf=0, in_ready=0 in reset cycle then 1;
//    mesg=0, mesg_valid=0, msg_len=0, err_ovf=0. Reset mid-message or mid-output
//    abandons everything; no partial block is ever presented.
//  Byte accepted when in_valid && in_ready. Byte k written to mesg[511-8k -: 8].
//  States:
//   COLLECT: in_ready=1. Each accept: count++ (saturates at MAX_LEN; further bytes
//     not written, ovf set). Accept with in_last -> PAD, or DROP if ovf/overflowing.
//   PAD (1 cycle, in_ready=0): byte[count]=0x80; bytes 56..63 = {count,3'b000}
//     as 64-bit LE (byte56 = LSB); other bytes already 0. -> OUT.
//   OUT: mesg_valid=1, in_ready=0, mesg and msg_len held stable.
//     mesg_valid && mesg_ready -> buffer cleared to 0, count=0 -> COLLECT.
//   DROP (1 cycle): err_ovf=1, buffer cleared, count=0, ovf=0 -> COLLECT.
//  Latency: last byte accepted in cycle N -> mesg_valid high in cycle N+2.
//  Throughput: one block per (len + 2) cycles with mesg_ready held high.
//  mesg_valid never drops without a handshake; mesg_ready ignored outside OUT.
//  Zero-length messages cannot be expressed (in_last requires a byte) -- unsupported.
//  Bit length width: count <= 55, so bits <= 440; upper length bytes 58..63 are 0.
//  X on in_data while in_valid=0 must not corrupt the buffer.
// STRUCTURE
//  Shared package md5_pkg: MD5_BLOCK_W=512, MD5_MAX_SINGLE=55, MD5_PAD_BYTE=8'h80,
//    state encoding localparams, byte-slot index helper function.
//  Single module. 512-bit buffer written through a byte-indexed write port
//    (one writer per cycle: data byte, pad marker, or length bytes in PAD).
//  No sub-module; the FSM and buffer stay flat.
// TESTING
//  1 "The quick brown fox jumps over the lazy dog" (43 B) -> mesg = 512'h54686520_
//    71756963_6b206272_6f776e20_666f7820_6a756d70_73206f76_65722074_6865206c_
//    617a7920_646f6780_0..0_58010000_00000000, msg_len=43, valid 2 cycles after last.
//  2 "abc" -> mesg[511:480]=32'h61626380, mesg[63:56]=8'h18, all other bits 0.
//  3 55 x 8'h41 -> byte55=8'h80, mesg[63:48]=16'hb801, msg_len=55, no err_ovf.
//  4 56 x 8'h41 -> err_ovf pulses once, no mesg_valid; next "abc" produces test 2 block.
//  5 mesg_ready low 5 cycles in OUT -> mesg_valid held, mesg stable, in_ready=0;
//    ready high -> handshake, back-to-back second message unaffected by first's bytes.
//  6 reset asserted after 10 of 43 bytes -> all outputs 0; rerun test 1 -> exact match.
//  Bench also runs md5core on outputs of tests 1/2 and checks digests against reference model.

Source files
------------

// File: rtl/md5_pkg.sv
// Shared MD5 constants: block geometry, padding marker, pad-FSM state encoding
// and the helper that maps a byte slot to its bit position in the block.
package md5_pkg;

   localparam int          MD5_BLOCK_W    = 512;
   localparam int          MD5_MAX_SINGLE = 55;
   localparam logic [7:0]  MD5_PAD_BYTE   = 8'h80;

   localparam logic [1:0]  ST_COLLECT = 2'd0;
   localparam logic [1:0]  ST_PAD     = 2'd1;
   localparam logic [1:0]  ST_OUT     = 2'd2;
   localparam logic [1:0]  ST_DROP    = 2'd3;

   // Byte k of the block lives at [511-8k -: 8]; return the LSB of that slot.
   function automatic logic [8:0] byte_slot_lsb(input logic [5:0] idx);
      return 9'd504 - {idx, 3'b000};
   endfunction

endpackage

// File: rtl/md5_msg_pad.sv
// Collects a byte stream into a single 512-bit MD5 block, applies the 0x80
// marker and little-endian bit length, then offers the block via valid/ready.
import md5_pkg::*;

module md5_msg_pad #(
   parameter int MAX_LEN = MD5_MAX_SINGLE
) (
   input  logic                   clk,
   input  logic                   reset,
   input  logic [7:0]             in_data,
   input  logic                   in_valid,
   input  logic                   in_last,
   output logic                   in_ready,
   output logic [MD5_BLOCK_W-1:0] mesg,
   output logic                   mesg_valid,
   input  logic                   mesg_ready,
   output logic [5:0]             msg_len,
   output logic                   err_ovf
);

   localparam logic [5:0] MAX_CNT = 6'(MAX_LEN);

   logic [1:0]             state_q, state_d;
   logic [MD5_BLOCK_W-1:0] buf_q, buf_d;
   logic [5:0]             count_q, count_d;
   logic                   ovf_q, ovf_d;
   logic                   accept;
   logic [15:0]            len_bits;

   assign len_bits = {7'd0, count_q, 3'b000};

   always_comb begin
      state_d  = state_q;
      buf_d    = buf_q;
      count_d  = count_q;
      ovf_d    = ovf_q;
      in_ready = (state_q == ST_COLLECT) && !reset;
      accept   = in_valid && in_ready;
      case (state_q)
         ST_COLLECT: begin
            if (accept) begin
               // Bytes beyond MAX_LEN are swallowed; the message is dropped on its last byte.
               if (count_q < MAX_CNT) begin
                  buf_d[byte_slot_lsb(count_q) +: 8] = in_data;
                  count_d = count_q + 6'd1;
               end else begin
                  ovf_d = 1'b1;
               end
               if (in_last) begin
                  state_d = (ovf_q || count_q == MAX_CNT) ? ST_DROP : ST_PAD;
               end
            end
         end
         ST_PAD: begin
            buf_d[byte_slot_lsb(count_q) +: 8] = MD5_PAD_BYTE;
            buf_d[byte_slot_lsb(6'd56) +: 8]   = len_bits[7:0];
            buf_d[byte_slot_lsb(6'd57) +: 8]   = len_bits[15:8];
            state_d = ST_OUT;
         end
         ST_OUT: begin
            if (mesg_ready) begin
               buf_d   = '0;
               count_d = '0;
               state_d = ST_COLLECT;
            end
         end
         default: begin
            buf_d   = '0;
            count_d = '0;
            ovf_d   = 1'b0;
            state_d = ST_COLLECT;
         end
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q <= ST_COLLECT;
         buf_q   <= '0;
         count_q <= '0;
         ovf_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         buf_q   <= buf_d;
         count_q <= count_d;
         ovf_q   <= ovf_d;
      end
   end

   // Block and length are only exposed while offered, so partial data never leaks.
   assign mesg_valid = (state_q == ST_OUT);
   assign mesg       = mesg_valid ? buf_q : '0;
   assign msg_len    = mesg_valid ? count_q : 6'd0;
   assign err_ovf    = (state_q == ST_DROP);

endmodule

// File: tb/tb_md5_msg_pad.sv
// Directed plus randomized bench for md5_msg_pad; expected blocks are built
// from the MD5 padding rules applied to the byte list of each message.
module tb_md5_msg_pad;

   logic         clk = 1'b0;
   logic         reset;
   logic [7:0]   in_data;
   logic         in_valid;
   logic         in_last;
   logic         in_ready;
   logic [511:0] mesg;
   logic         mesg_valid;
   logic         mesg_ready;
   logic [5:0]   msg_len;
   logic         err_ovf;

   int vectors     = 0;
   int miscompares = 0;

   logic [7:0] msg_q[$];

   md5_msg_pad dut (
      .clk        (clk),
      .reset      (reset),
      .in_data    (in_data),
      .in_valid   (in_valid),
      .in_last    (in_last),
      .in_ready   (in_ready),
      .mesg       (mesg),
      .mesg_valid (mesg_valid),
      .mesg_ready (mesg_ready),
      .msg_len    (msg_len),
      .err_ovf    (err_ovf)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [511:0] obs, input logic [511:0] exp);
      vectors++;
      assert (obs === exp) else begin
         miscompares++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   // Reference: message bytes, then 0x80, zeros, then bit length as 64-bit little-endian.
   function automatic logic [511:0] model_block();
      logic [7:0]  bytes[64];
      logic [63:0] bits;
      logic [511:0] blk;
      for (int k = 0; k < 64; k++) bytes[k] = 8'h00;
      for (int k = 0; k < msg_q.size(); k++) bytes[k] = msg_q[k];
      bytes[msg_q.size()] = 8'h80;
      bits = 64'(msg_q.size()) * 64'd8;
      for (int i = 0; i < 8; i++) bytes[56 + i] = bits[8*i +: 8];
      blk = '0;
      for (int k = 0; k < 64; k++) blk[511 - 8*k -: 8] = bytes[k];
      return blk;
   endfunction

   task automatic load_str(input string s);
      msg_q.delete();
      for (int i = 0; i < s.len(); i++) msg_q.push_back(s[i]);
   endtask

   task automatic load_fill(input int n, input logic [7:0] b);
      msg_q.delete();
      for (int i = 0; i < n; i++) msg_q.push_back(b);
   endtask

   task automatic load_rand(input int n);
      msg_q.delete();
      for (int i = 0; i < n; i++) msg_q.push_back(8'($urandom));
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Sends msg_q; bubbles carry random data that must not reach the buffer.
   task automatic send_msg(input bit bubbles, input int stop_after);
      for (int i = 0; i < msg_q.size() && i < stop_after; i++) begin
         if (bubbles && ($urandom_range(0, 3) == 0)) begin
            in_valid = 1'b0;
            in_data  = 8'($urandom);
            in_last  = 1'($urandom);
            tick();
         end
         in_valid = 1'b1;
         in_data  = msg_q[i];
         in_last  = (i == msg_q.size() - 1);
         tick();
      end
      in_valid = 1'b0;
      in_last  = 1'b0;
      in_data  = 8'($urandom);
   endtask

   // After the last byte: one PAD cycle, then the block is offered.
   task automatic expect_block(input string tag, input int wait_cycles);
      logic [511:0] exp;
      exp = model_block();
      chk({tag, "_pad_not_valid"}, {511'd0, mesg_valid}, 512'd0);
      tick();
      chk({tag, "_valid"}, {511'd0, mesg_valid}, 512'd1);
      chk({tag, "_mesg"}, mesg, exp);
      chk({tag, "_len"}, {506'd0, msg_len}, 512'(msg_q.size()));
      chk({tag, "_in_ready"}, {511'd0, in_ready}, 512'd0);
      for (int c = 0; c < wait_cycles; c++) begin
         in_valid = 1'b1;
         in_data  = 8'($urandom);
         tick();
         chk({tag, "_hold_valid"}, {511'd0, mesg_valid}, 512'd1);
         chk({tag, "_hold_mesg"}, mesg, exp);
      end
      in_valid   = 1'b0;
      mesg_ready = 1'b1;
      tick();
      mesg_ready = 1'b0;
      chk({tag, "_released"}, {511'd0, mesg_valid}, 512'd0);
      chk({tag, "_ready_again"}, {511'd0, in_ready}, 512'd1);
   endtask

   task automatic expect_drop(input string tag);
      chk({tag, "_err_pulse"}, {511'd0, err_ovf}, 512'd1);
      chk({tag, "_no_valid"}, {511'd0, mesg_valid}, 512'd0);
      tick();
      chk({tag, "_err_clear"}, {511'd0, err_ovf}, 512'd0);
      chk({tag, "_no_valid2"}, {511'd0, mesg_valid}, 512'd0);
      chk({tag, "_ready_again"}, {511'd0, in_ready}, 512'd1);
   endtask

   initial begin
      logic [511:0] fox_blk;
      logic [511:0] abc_blk;
      int n;
      fox_blk = 512'h54686520_71756963_6b206272_6f776e20_666f7820_6a756d70_73206f76_65722074_6865206c_617a7920_646f6780_00000000_00000000_00000000_58010000_00000000;
      abc_blk = {32'h61626380, 416'd0, 8'h18, 56'd0};

      reset = 1'b1; in_valid = 1'b0; in_last = 1'b0; in_data = 8'h00; mesg_ready = 1'b0;
      tick();
      tick();
      chk("rst_in_ready", {511'd0, in_ready}, 512'd0);
      chk("rst_mesg", mesg, 512'd0);
      chk("rst_valid", {511'd0, mesg_valid}, 512'd0);
      chk("rst_len", {506'd0, msg_len}, 512'd0);
      chk("rst_err", {511'd0, err_ovf}, 512'd0);
      reset = 1'b0;
      #1;
      chk("post_rst_in_ready", {511'd0, in_ready}, 512'd1);

      // 1: quick brown fox, literal block
      load_str("The quick brown fox jumps over the lazy dog");
      send_msg(1'b0, 1000);
      tick();
      chk("fox_valid", {511'd0, mesg_valid}, 512'd1);
      chk("fox_literal", mesg, fox_blk);
      chk("fox_len", {506'd0, msg_len}, 512'd43);
      mesg_ready = 1'b1; tick(); mesg_ready = 1'b0;

      // 2: abc
      load_str("abc");
      send_msg(1'b0, 1000);
      tick();
      chk("abc_literal", mesg, abc_blk);
      mesg_ready = 1'b1; tick(); mesg_ready = 1'b0;

      // 3: exactly MAX_LEN bytes
      load_fill(55, 8'h41);
      send_msg(1'b0, 1000);
      chk("max_no_err", {511'd0, err_ovf}, 512'd0);
      tick();
      chk("max_byte55", {504'd0, mesg[511 - 8*55 -: 8]}, 512'h80);
      chk("max_len_bytes", {496'd0, mesg[63:48]}, 512'hb801);
      chk("max_len", {506'd0, msg_len}, 512'd55);
      chk("max_err_low", {511'd0, err_ovf}, 512'd0);
      mesg_ready = 1'b1; tick(); mesg_ready = 1'b0;

      // 4: one byte too many, then abc recovers cleanly
      load_fill(56, 8'h41);
      send_msg(1'b0, 1000);
      expect_drop("ovf56");
      load_str("abc");
      send_msg(1'b0, 1000);
      tick();
      chk("after_ovf_abc", mesg, abc_blk);
      mesg_ready = 1'b1; tick(); mesg_ready = 1'b0;

      // 5: backpressure, then back-to-back short message
      load_str("The quick brown fox jumps over the lazy dog");
      send_msg(1'b1, 1000);
      expect_block("stall", 5);
      load_str("hi");
      send_msg(1'b0, 1000);
      expect_block("b2b", 0);

      // 6: reset mid-message
      load_str("The quick brown fox jumps over the lazy dog");
      send_msg(1'b0, 10);
      reset = 1'b1;
      tick();
      chk("midrst_mesg", mesg, 512'd0);
      chk("midrst_valid", {511'd0, mesg_valid}, 512'd0);
      chk("midrst_len", {506'd0, msg_len}, 512'd0);
      chk("midrst_err", {511'd0, err_ovf}, 512'd0);
      chk("midrst_in_ready", {511'd0, in_ready}, 512'd0);
      reset = 1'b0;
      send_msg(1'b0, 1000);
      tick();
      chk("rerun_fox", mesg, fox_blk);
      mesg_ready = 1'b1; tick(); mesg_ready = 1'b0;

      // Randomized messages, including some over-length ones
      for (int t = 0; t < 40; t++) begin
         n = $urandom_range(1, 62);
         load_rand(n);
         send_msg(1'b1, 1000);
         if (n > 55) expect_drop("rnd_ovf");
         else expect_block("rnd", $urandom_range(0, 3));
      end

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
